seq_alu: RTL and testbench

Parametrised, handshaked successor to the team's 4-bit combinational ALU. Accepts one operation per transaction on a valid/ready input port, computes the result over one or more clock cycles, and presents it on a valid/ready output port together with registered status flags. It keeps the original eight opcodes bit-compatible, adds a carry flag that persists between operations, and adds four operations, including a multi-cycle serial multiply. It sits between operand/opcode sources (register file or test sequencer) and the result consumer.

---
 rtl/seq_alu.sv | 149 ++++++++++++++
 tb/tb_seq_alu.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked sequential ALU with persistent carry flag and serial multiply
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             err
);

  localparam int CW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t             state;
  logic [3:0]         op_r;
  logic [WIDTH-1:0]   x_r, y_r;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;
  logic               cflag;

  logic [WIDTH-1:0] r;
  logic             c, v;
  logic [WIDTH:0]   add_w, adc_w, sub_w, mul_sum;

  assign in_ready = !reset && (state == IDLE);

  assign add_w   = {1'b0, x_r} + {1'b0, y_r};
  assign adc_w   = add_w + {{WIDTH{1'b0}}, cflag};
  assign sub_w   = {1'b0, x_r} - {1'b0, y_r};
  // Right-shifting shift-add: high half accumulates, multiplier bits retire from the low end.
  assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, x_r} : {(WIDTH+1){1'b0}});

  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (op_r)
      4'b0000: r = x_r & y_r;
      4'b0001: r = ~x_r;
      4'b0010: r = x_r | y_r;
      4'b0011: r = x_r ^ y_r;
      4'b0100: begin r = {x_r[MSB-1:0], 1'b0}; c = x_r[MSB]; end
      4'b0101: begin
        r = add_w[MSB:0];
        c = add_w[WIDTH];
        v = (x_r[MSB] == y_r[MSB]) && (add_w[MSB] != x_r[MSB]);
      end
      4'b0110: begin
        r = sub_w[MSB:0];
        c = sub_w[WIDTH];
        v = (x_r[MSB] != y_r[MSB]) && (sub_w[MSB] != x_r[MSB]);
      end
      4'b0111: begin
        r = -x_r;
        c = (x_r == '0);
        v = (x_r == {1'b1, {(WIDTH-1){1'b0}}});
      end
      4'b1001: begin
        r = adc_w[MSB:0];
        c = adc_w[WIDTH];
        v = (x_r[MSB] == y_r[MSB]) && (adc_w[MSB] != x_r[MSB]);
      end
      4'b1010: begin r = {1'b0, x_r[MSB:1]}; c = x_r[0]; end
      4'b1011: begin r = {x_r[MSB-1:0], x_r[MSB]}; c = x_r[MSB]; end
      default: r = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_r      <= '0;
      x_r       <= '0;
      y_r       <= '0;
      prod      <= '0;
      cnt       <= '0;
      cflag     <= 1'b0;
      out       <= '0;
      out_hi    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_r  <= op;
          x_r   <= x;
          y_r   <= y;
          cnt   <= '0;
          prod  <= {{WIDTH{1'b0}}, y};
          state <= (op == 4'b1000) ? MUL : EXEC;
        end
        EXEC: begin
          out       <= r;
          out_hi    <= '0;
          zero      <= (r == '0);
          overflow  <= v;
          out_valid <= 1'b1;
          state     <= DONE;
          // Reserved opcodes leave both the visible carry and cflag untouched.
          if (op_r[3:2] == 2'b11) begin
            err <= 1'b1;
          end else begin
            err   <= 1'b0;
            carry <= c;
            cflag <= c;
          end
        end
        MUL: begin
          if (cnt == CW'(WIDTH)) begin
            out       <= prod[WIDTH-1:0];
            out_hi    <= prod[2*WIDTH-1:WIDTH];
            carry     <= |prod[2*WIDTH-1:WIDTH];
            cflag     <= |prod[2*WIDTH-1:WIDTH];
            zero      <= (prod[WIDTH-1:0] == '0);
            overflow  <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            prod <= {mul_sum, prod[WIDTH-1:1]};
            cnt  <= cnt + CW'(1);
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized self-checking bench for seq_alu against an arithmetic model
module tb_seq_alu;
  localparam int W = 4;
  localparam int M = 16;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   op;
  logic [W-1:0] x, y, out, out_hi;
  logic         carry, zero, overflow, err;

  int n_checks = 0;
  int n_pass   = 0;
  int m_cflag  = 0;
  int m_carry  = 0;
  int last_out, last_hi;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_hi(out_hi), .carry(carry), .zero(zero),
    .overflow(overflow), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int sgn(input int a);
    return (a >= M/2) ? a - M : a;
  endfunction

  function automatic bit ovf(input int s);
    return (s > M/2 - 1) || (s < -M/2);
  endfunction

  task automatic model(input int o, input int a, input int b,
                       output int r, output int hi, output int c,
                       output int z, output int v, output int e);
    int s;
    r = 0; hi = 0; c = 0; v = 0; e = 0;
    case (o)
      0: r = a & b;
      1: r = M - 1 - a;
      2: r = a | b;
      3: r = a ^ b;
      4: begin r = (a * 2) % M; c = int'(a >= M/2); end
      5: begin s = a + b; r = s % M; c = int'(s >= M); v = int'(ovf(sgn(a) + sgn(b))); end
      6: begin r = (a - b + M) % M; c = int'(a < b); v = int'(ovf(sgn(a) - sgn(b))); end
      7: begin r = (M - a) % M; c = int'(a == 0); v = int'(a == M/2); end
      8: begin s = a * b; r = s % M; hi = s / M; c = int'(hi != 0); end
      9: begin
        s = a + b + m_cflag; r = s % M; c = int'(s >= M);
        v = int'(ovf(sgn(a) + sgn(b) + m_cflag));
      end
      10: begin r = a / 2; c = a % 2; end
      11: begin r = (a * 2) % M + a / (M/2); c = int'(a >= M/2); end
      default: begin e = 1; c = m_carry; end
    endcase
    z = int'(r == 0);
  endtask

  task automatic run_op(input int o, input int a, input int b, input int stall);
    int r, hi, c, z, v, e, lat;
    logic [W-1:0] s_out, s_hi;
    logic [3:0]   s_flags;
    model(o, a, b, r, hi, c, z, v, e);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; op = 4'(o); x = W'(a); y = W'(b);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; op = 4'($urandom); x = W'($urandom); y = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      check("busy_in_ready", in_ready, 0);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b0;
    check("latency", lat, (o == 8) ? W + 1 : 1);
    check("out", out, r);
    check("out_hi", out_hi, hi);
    check("carry", carry, c);
    check("zero", zero, z);
    check("overflow", overflow, v);
    check("err", err, e);
    last_out = int'(out); last_hi = int'(out_hi);
    s_out = out; s_hi = out_hi; s_flags = {carry, zero, overflow, err};
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; op = 4'($urandom); x = W'($urandom); y = W'($urandom);
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_ready", in_ready, 0);
      check("stall_out", {s_hi, s_out}, {out_hi, out});
      check("stall_flags", s_flags, {carry, zero, overflow, err});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_ready", in_ready, 1);
    if (e == 0) m_cflag = c;
    m_carry = c;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    check("rst_state", {out_valid, in_ready, carry, zero, overflow, err}, 6'b0);
    check("rst_out", {out_hi, out}, 8'h00);
    reset = 1'b0;

    run_op(5, 4'b1011, 4'b0010, 0);
    check("plan_add", last_out, 4'b1101);
    for (int o = 0; o < 8; o++) run_op(o, 4'b1011, 4'b0010, 0);
    run_op(8, 4'b1011, 4'b0010, 1);
    check("plan_mul", {last_hi[3:0], last_out[3:0]}, 8'b0001_0110);
    run_op(5, 4'b1111, 4'b0001, 0);
    run_op(9, 4'b0000, 4'b0000, 0);
    check("plan_adc", last_out, 4'b0001);
    run_op(7, 4'b1000, 4'b0000, 0);
    run_op(6, 4'b0001, 4'b0011, 0);
    run_op(12, 4'b0101, 4'b0101, 0);
    run_op(9, 4'b0111, 4'b0000, 0);
    run_op(3, 4'b0110, 4'b1100, 3);

    run_op(5, 4'b1111, 4'b0001, 0);
    @(negedge clk);
    in_valid = 1'b1; op = 4'b1000; x = 4'b1011; y = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; op = 4'b0101;
    @(negedge clk);
    check("abort_state", {out_valid, in_ready, carry, zero, overflow, err}, 6'b0);
    check("abort_out", {out_hi, out}, 8'h00);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("abort_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_valid", out_valid, 0);
    end
    m_cflag = 0; m_carry = 0;
    run_op(9, 4'b0000, 4'b0000, 0);

    for (int i = 0; i < 150; i++)
      run_op($urandom_range(0, 15), $urandom_range(0, M - 1), $urandom_range(0, M - 1),
             $urandom_range(0, 2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
